// File: rtl/xsm_capture_pkg.sv
// Shared types and constants for the XSM multi-channel capture path.
// The entry struct below is the default-width layout of one FIFO word.
package xsm_capture_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } cap_state_e;

    localparam logic [15:0] OVF_MAX = 16'hFFFF;

    localparam int DEF_TS_W     = 48;
    localparam int DEF_CH_W     = 3;
    localparam int DEF_SAMPLE_W = 16;

    typedef struct packed {
        logic [DEF_TS_W-1:0]     ts;
        logic [DEF_CH_W-1:0]     ch;
        logic [DEF_SAMPLE_W-1:0] sample;
    } cap_entry_t;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == OVF_MAX) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/xsm_sync_fifo.sv
// Show-ahead synchronous FIFO with occupancy output.
// Head data reads as zero while empty so the stream outputs are clean.
module xsm_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH),
    parameter int LW    = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [LW-1:0]    level
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q, wr_d;
    logic [AW-1:0]    rd_q, rd_d;
    logic [LW-1:0]    cnt_q, cnt_d;
    logic             do_push;
    logic             do_pop;

    assign full    = (cnt_q == LW'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign level   = cnt_q;
    assign dout    = empty ? '0 : mem_q[rd_q];

    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (do_push) wr_d = wr_q + AW'(1);
        if (do_pop)  rd_d = rd_q + AW'(1);
        unique case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + LW'(1);
            2'b01:   cnt_d = cnt_q - LW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= din;
    end

endmodule

// File: rtl/xsm_capture_multich.sv
// Multi-channel ADC capture: trigger snapshot, timestamp tag,
// serialisation of enabled channels into a show-ahead FIFO.
module xsm_capture_multich
    import xsm_capture_pkg::*;
#(
    parameter int NUM_CH       = 8,
    parameter int SAMPLE_WIDTH = 16,
    parameter int TS_WIDTH     = 48,
    parameter int FIFO_DEPTH   = 16,
    parameter int CH_W         = $clog2(NUM_CH)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_CH*SAMPLE_WIDTH-1:0] adc_data,
    input  logic                           capture_en,
    input  logic                           trigger_in,
    input  logic                           cont_mode,
    input  logic [NUM_CH-1:0]              ch_mask,
    output logic [TS_WIDTH-1:0]            mono_counter,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [SAMPLE_WIDTH-1:0]        out_sample,
    output logic [CH_W-1:0]                out_channel,
    output logic [TS_WIDTH-1:0]            out_timestamp,
    output logic                           busy,
    output logic [$clog2(FIFO_DEPTH):0]    fifo_level,
    output logic [15:0]                    overflow_cnt
);

    typedef struct packed {
        logic [TS_WIDTH-1:0]     ts;
        logic [CH_W-1:0]         ch;
        logic [SAMPLE_WIDTH-1:0] sample;
    } entry_t;

    localparam int EW = $bits(entry_t);

    logic [TS_WIDTH-1:0]     mono_q, mono_d;
    logic                    trig_q, trig_d;
    logic [15:0]             ovf_q, ovf_d;

    cap_state_e              state_q;
    logic [CH_W-1:0]         idx_q;
    logic [SAMPLE_WIDTH-1:0] snap_q [NUM_CH];
    logic [NUM_CH-1:0]       mask_q;
    logic [TS_WIDTH-1:0]     ts_q;
    logic                    push_q;
    entry_t                  entry_q;

    entry_t                  head;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic                    rise;
    logic                    last;

    assign rise = trigger_in & ~trig_q;
    assign last = (idx_q == CH_W'(NUM_CH - 1));

    always_comb begin
        mono_d = mono_q + TS_WIDTH'(1);
        trig_d = trigger_in;
        ovf_d  = ovf_q;
        // Full is sampled before the same-cycle pop frees a slot.
        if (push_q && fifo_full) ovf_d = sat_inc(ovf_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mono_q <= '0;
            trig_q <= 1'b1;
            ovf_q  <= '0;
        end else begin
            mono_q <= mono_d;
            trig_q <= trig_d;
            ovf_q  <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            mask_q  <= '0;
            ts_q    <= '0;
            push_q  <= 1'b0;
            entry_q <= '0;
            for (int i = 0; i < NUM_CH; i++) snap_q[i] <= '0;
        end else begin
            push_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (rise && capture_en) begin
                        state_q <= SCAN;
                        idx_q   <= '0;
                        mask_q  <= ch_mask;
                        ts_q    <= mono_q;
                        for (int i = 0; i < NUM_CH; i++)
                            snap_q[i] <= adc_data[i*SAMPLE_WIDTH +: SAMPLE_WIDTH];
                    end
                end
                SCAN: begin
                    push_q  <= mask_q[idx_q];
                    entry_q <= '{ts: ts_q, ch: idx_q, sample: snap_q[idx_q]};
                    if (!last) begin
                        idx_q <= idx_q + CH_W'(1);
                    end else if (cont_mode && capture_en) begin
                        // Next sweep starts on the very next cycle.
                        idx_q  <= '0;
                        mask_q <= ch_mask;
                        ts_q   <= mono_q;
                        for (int i = 0; i < NUM_CH; i++)
                            snap_q[i] <= adc_data[i*SAMPLE_WIDTH +: SAMPLE_WIDTH];
                    end else begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    xsm_sync_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_q),
        .din   (entry_q),
        .pop   (out_valid & out_ready),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    assign mono_counter  = mono_q;
    assign out_valid     = ~fifo_empty;
    assign out_sample    = head.sample;
    assign out_channel   = head.ch;
    assign out_timestamp = head.ts;
    assign busy          = (state_q == SCAN);
    assign overflow_cnt  = ovf_q;

endmodule
